// File: rtl/ascon_fsm_ctrl.sv
// ASCON-128 encryption control FSM: sequences initialisation, one AD block,
// NB_BLOCKS plaintext blocks and finalisation, one permutation round per clock.
module ascon_fsm_ctrl #(
    parameter int NB_BLOCKS = 4
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    input  logic [3:0] round_i,
    output logic       data_ready_o,
    output logic       en_cpt_o,
    output logic       init_p12_o,
    output logic       init_p6_o,
    output logic       init_state_o,
    output logic       en_reg_state_o,
    output logic       en_xor_data_begin_o,
    output logic       en_xor_key_begin_o,
    output logic       en_xor_key_end_o,
    output logic       en_xor_lsb_end_o,
    output logic       en_cipher_o,
    output logic       en_tag_o,
    output logic       end_o
);

    localparam int CNT_W = (NB_BLOCKS > 1) ? $clog2(NB_BLOCKS) : 1;
    localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(NB_BLOCKS - 1);
    localparam logic [3:0] LAST_ROUND = 4'd11;

    typedef enum logic [2:0] {
        IDLE,
        CONF_INIT,
        INIT_RUN,
        WAIT_AD,
        AD_RUN,
        WAIT_PT,
        PT_RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] block_cnt;
    logic             last_round;
    logic             last_blk;
    logic             next_is_last;

    assign last_round = (round_i == LAST_ROUND);
    assign last_blk   = (block_cnt == LAST_BLK);
    // The last block runs the full p12 (it is the finalisation), all others p6.
    assign next_is_last = (state == AD_RUN) ? (LAST_BLK == '0)
                                            : ((block_cnt + CNT_W'(1)) == LAST_BLK);

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            block_cnt <= '0;
        end else if (state == AD_RUN && last_round) begin
            block_cnt <= '0;
        end else if (state == PT_RUN && last_round && !last_blk) begin
            block_cnt <= block_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start_i) state_next = CONF_INIT;
            CONF_INIT: state_next = INIT_RUN;
            INIT_RUN:  if (last_round) state_next = WAIT_AD;
            WAIT_AD:   if (data_valid_i) state_next = AD_RUN;
            AD_RUN:    if (last_round) state_next = WAIT_PT;
            WAIT_PT:   if (data_valid_i) state_next = PT_RUN;
            PT_RUN:    if (last_round) state_next = last_blk ? DONE : WAIT_PT;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        data_ready_o        = 1'b0;
        en_cpt_o            = 1'b0;
        init_p12_o          = 1'b0;
        init_p6_o           = 1'b0;
        init_state_o        = 1'b0;
        en_reg_state_o      = 1'b0;
        en_xor_data_begin_o = 1'b0;
        en_xor_key_begin_o  = 1'b0;
        en_xor_key_end_o    = 1'b0;
        en_xor_lsb_end_o    = 1'b0;
        en_cipher_o         = 1'b0;
        en_tag_o            = 1'b0;
        end_o               = 1'b0;
        case (state)
            CONF_INIT: begin
                init_state_o   = 1'b1;
                en_reg_state_o = 1'b1;
                en_cpt_o       = 1'b1;
                init_p12_o     = 1'b1;
            end
            INIT_RUN: begin
                en_reg_state_o = 1'b1;
                en_cpt_o       = 1'b1;
                if (last_round) begin
                    en_xor_key_end_o = 1'b1;
                    init_p6_o        = 1'b1;
                end
            end
            WAIT_AD: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    en_xor_data_begin_o = 1'b1;
                    en_reg_state_o      = 1'b1;
                    en_cpt_o            = 1'b1;
                end
            end
            AD_RUN: begin
                en_reg_state_o = 1'b1;
                en_cpt_o       = 1'b1;
                if (last_round) begin
                    en_xor_lsb_end_o = 1'b1;
                    init_p12_o       = next_is_last;
                    init_p6_o        = !next_is_last;
                end
            end
            WAIT_PT: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    en_xor_data_begin_o = 1'b1;
                    en_cipher_o         = 1'b1;
                    en_reg_state_o      = 1'b1;
                    en_cpt_o            = 1'b1;
                    en_xor_key_begin_o  = last_blk;
                end
            end
            PT_RUN: begin
                en_reg_state_o = 1'b1;
                en_cpt_o       = 1'b1;
                if (last_round) begin
                    if (last_blk) begin
                        en_xor_key_end_o = 1'b1;
                        en_tag_o         = 1'b1;
                    end else begin
                        init_p12_o = next_is_last;
                        init_p6_o  = !next_is_last;
                    end
                end
            end
            DONE: begin
                end_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ascon_fsm_ctrl.sv
// Bench for ascon_fsm_ctrl: two instances (NB_BLOCKS=4 and 1) checked every cycle
// against a round-schedule model, plus literal timeline checks.
module tb_ascon_fsm_ctrl;

    localparam int B_READY = 12;
    localparam int B_CPT   = 11;
    localparam int B_P12   = 10;
    localparam int B_P6    = 9;
    localparam int B_INIT  = 8;
    localparam int B_REG   = 7;
    localparam int B_XDB   = 6;
    localparam int B_XKB   = 5;
    localparam int B_XKE   = 4;
    localparam int B_XLE   = 3;
    localparam int B_CIPH  = 2;
    localparam int B_TAG   = 1;
    localparam int B_END   = 0;

    localparam logic [12:0] O_READY = 13'(1) << B_READY;
    localparam logic [12:0] O_CPT   = 13'(1) << B_CPT;
    localparam logic [12:0] O_P12   = 13'(1) << B_P12;
    localparam logic [12:0] O_P6    = 13'(1) << B_P6;
    localparam logic [12:0] O_INIT  = 13'(1) << B_INIT;
    localparam logic [12:0] O_REG   = 13'(1) << B_REG;
    localparam logic [12:0] O_XDB   = 13'(1) << B_XDB;
    localparam logic [12:0] O_XKB   = 13'(1) << B_XKB;
    localparam logic [12:0] O_XKE   = 13'(1) << B_XKE;
    localparam logic [12:0] O_XLE   = 13'(1) << B_XLE;
    localparam logic [12:0] O_CIPH  = 13'(1) << B_CIPH;
    localparam logic [12:0] O_TAG   = 13'(1) << B_TAG;
    localparam logic [12:0] O_END   = 13'(1) << B_END;
    localparam logic [12:0] RUN     = O_REG | O_CPT;
    localparam logic [12:0] O_CONF  = O_INIT | O_REG | O_CPT | O_P12;

    logic        clock_i;
    logic        resetb_i;
    logic        start_i;
    logic        data_valid_i;
    logic [3:0]  round4;
    logic [3:0]  round1;
    wire  [12:0] out4;
    wire  [12:0] out1;

    int checks;
    int failures;

    // Expected behaviour as a per-message script of steps (one per cycle, wait steps repeat)
    logic        script_w [2][80];
    int          script_r [2][80];
    logic [12:0] script_v [2][80];
    logic [12:0] script_a [2][80];
    int          len [2];
    int          pos [2];

    logic        trace_on;
    int          tcyc;
    logic [12:0] trace4 [64];
    logic [12:0] trace1 [64];
    logic [3:0]  rtrace4 [64];

    ascon_fsm_ctrl #(.NB_BLOCKS(4)) dut4 (
        .clock_i             (clock_i),
        .resetb_i            (resetb_i),
        .start_i             (start_i),
        .data_valid_i        (data_valid_i),
        .round_i             (round4),
        .data_ready_o        (out4[B_READY]),
        .en_cpt_o            (out4[B_CPT]),
        .init_p12_o          (out4[B_P12]),
        .init_p6_o           (out4[B_P6]),
        .init_state_o        (out4[B_INIT]),
        .en_reg_state_o      (out4[B_REG]),
        .en_xor_data_begin_o (out4[B_XDB]),
        .en_xor_key_begin_o  (out4[B_XKB]),
        .en_xor_key_end_o    (out4[B_XKE]),
        .en_xor_lsb_end_o    (out4[B_XLE]),
        .en_cipher_o         (out4[B_CIPH]),
        .en_tag_o            (out4[B_TAG]),
        .end_o               (out4[B_END])
    );

    ascon_fsm_ctrl #(.NB_BLOCKS(1)) dut1 (
        .clock_i             (clock_i),
        .resetb_i            (resetb_i),
        .start_i             (start_i),
        .data_valid_i        (data_valid_i),
        .round_i             (round1),
        .data_ready_o        (out1[B_READY]),
        .en_cpt_o            (out1[B_CPT]),
        .init_p12_o          (out1[B_P12]),
        .init_p6_o           (out1[B_P6]),
        .init_state_o        (out1[B_INIT]),
        .en_reg_state_o      (out1[B_REG]),
        .en_xor_data_begin_o (out1[B_XDB]),
        .en_xor_key_begin_o  (out1[B_XKB]),
        .en_xor_key_end_o    (out1[B_XKE]),
        .en_xor_lsb_end_o    (out1[B_XLE]),
        .en_cipher_o         (out1[B_CIPH]),
        .en_tag_o            (out1[B_TAG]),
        .end_o               (out1[B_END])
    );

    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    // Round counters driven by each FSM's enable/preset outputs
    always @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            round4 <= 4'd0;
            round1 <= 4'd0;
        end else begin
            if (out4[B_CPT]) round4 <= out4[B_P12] ? 4'd0 : (out4[B_P6] ? 4'd6 : round4 + 4'd1);
            if (out1[B_CPT]) round1 <= out1[B_P12] ? 4'd0 : (out1[B_P6] ? 4'd6 : round1 + 4'd1);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_step(input int d, input logic w, input int r,
                             input logic [12:0] v, input logic [12:0] a);
        script_w[d][len[d]] = w;
        script_r[d][len[d]] = r;
        script_v[d][len[d]] = v;
        script_a[d][len[d]] = a;
        len[d]++;
    endtask

    task automatic build_script(input int d, input int nb);
        logic [12:0] v;
        logic        last;
        pos[d] = 0;
        len[d] = 0;
        push_step(d, 1'b0, -1, O_CONF, O_CONF);
        for (int r = 0; r < 12; r++) begin
            v = (r == 11) ? (RUN | O_XKE | O_P6) : RUN;
            push_step(d, 1'b0, r, v, v);
        end
        push_step(d, 1'b1, 6, O_READY, O_READY | O_XDB | RUN);
        for (int r = 7; r < 12; r++) begin
            v = (r == 11) ? (RUN | O_XLE | ((nb == 1) ? O_P12 : O_P6)) : RUN;
            push_step(d, 1'b0, r, v, v);
        end
        for (int b = 0; b < nb; b++) begin
            last = (b == nb - 1);
            push_step(d, 1'b1, last ? 0 : 6, O_READY,
                      O_READY | O_XDB | O_CIPH | RUN | (last ? O_XKB : 13'd0));
            for (int r = (last ? 1 : 7); r < 12; r++) begin
                v = RUN;
                if (r == 11) v = v | (last ? (O_XKE | O_TAG) : ((b + 1 == nb - 1) ? O_P12 : O_P6));
                push_step(d, 1'b0, r, v, v);
            end
        end
        push_step(d, 1'b0, -1, O_END, O_END);
    endtask

    task automatic model_cycle(input int d, input int nb, input logic [12:0] act, input logic [3:0] rnd);
        logic [12:0] exp_v;
        int          exp_r;
        logic        stall;
        exp_v = '0;
        exp_r = -1;
        if (!resetb_i) begin
            pos[d] = 0;
            len[d] = 0;
        end else if (pos[d] >= len[d]) begin
            if (start_i) build_script(d, nb);
        end else begin
            stall = script_w[d][pos[d]] && !data_valid_i;
            exp_r = script_r[d][pos[d]];
            exp_v = stall ? script_v[d][pos[d]] : script_a[d][pos[d]];
            if (!stall) pos[d]++;
        end
        checkOutput($sformatf("nb%0d_outputs@%0t", nb, $time), 64'(act), 64'(exp_v));
        if (exp_r >= 0) checkOutput($sformatf("nb%0d_round@%0t", nb, $time), 64'(rnd), 64'(exp_r));
    endtask

    task automatic compare_all();
        model_cycle(0, 4, out4, round4);
        model_cycle(1, 1, out1, round1);
        if (trace_on && tcyc < 64) begin
            trace4[tcyc]  = out4;
            trace1[tcyc]  = out1;
            rtrace4[tcyc] = round4;
            tcyc++;
        end
    endtask

    // One clock cycle of stimulus; rst drops resetb_i mid-cycle, away from any edge
    task automatic applyStimulus(input logic s, input logic v, input logic rst);
        @(posedge clock_i);
        #1;
        start_i      = s;
        data_valid_i = v;
        if (!rst) begin
            resetb_i = 1'b1;
        end else begin
            #2 resetb_i = 1'b0;
            #1;
            checkOutput("async_reset_nb4", 64'(out4), 64'd0);
            checkOutput("async_reset_nb1", 64'(out1), 64'd0);
        end
        @(negedge clock_i);
        compare_all();
    endtask

    task automatic reset_pulse();
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
    endtask

    task automatic run_trace(input logic hold, input logic stall);
        trace_on = 1'b1;
        tcyc = 0;
        for (int c = 0; c < 64; c++)
            applyStimulus((c == 0) || hold, !(stall && c >= 26 && c <= 28), 1'b0);
        trace_on = 1'b0;
    endtask

    function automatic logic [63:0] at(input int n);
        return 64'd1 << n;
    endfunction

    function automatic logic [63:0] cycles4(input int b);
        logic [63:0] m;
        m = '0;
        for (int c = 0; c < 64; c++) m[c] = trace4[c][b];
        return m;
    endfunction

    function automatic logic [63:0] cycles1(input int b);
        logic [63:0] m;
        m = '0;
        for (int c = 0; c < 64; c++) m[c] = trace1[c][b];
        return m;
    endfunction

    task automatic check_nominal4(input string tag);
        checkOutput({tag, "_ready"}, cycles4(B_READY), at(14) | at(20) | at(26) | at(32) | at(38));
        checkOutput({tag, "_cipher"}, cycles4(B_CIPH), at(20) | at(26) | at(32) | at(38));
        checkOutput({tag, "_key_begin"}, cycles4(B_XKB), at(38));
        checkOutput({tag, "_key_end"}, cycles4(B_XKE), at(13) | at(49));
        checkOutput({tag, "_tag"}, cycles4(B_TAG), at(49));
        checkOutput({tag, "_end"}, cycles4(B_END), at(50));
        checkOutput({tag, "_p6"}, cycles4(B_P6), at(13) | at(19) | at(25) | at(31));
        checkOutput({tag, "_p12"}, cycles4(B_P12), at(1) | at(37));
        checkOutput({tag, "_conf_init"}, 64'(trace4[1]), 64'(O_CONF));
        checkOutput({tag, "_round_c2"}, 64'(rtrace4[2]), 64'd0);
        checkOutput({tag, "_round_c14"}, 64'(rtrace4[14]), 64'd6);
        checkOutput({tag, "_round_c38"}, 64'(rtrace4[38]), 64'd0);
        checkOutput({tag, "_idle_c51"}, 64'(trace4[51]), 64'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        resetb_i     = 1'b0;
        start_i      = 1'b0;
        data_valid_i = 1'b0;
        trace_on     = 1'b0;
        tcyc         = 0;
        pos[0] = 0; pos[1] = 0;
        len[0] = 0; len[1] = 0;

        $display("[TB] nominal run");
        reset_pulse();
        run_trace(1'b0, 1'b0);
        check_nominal4("nom");
        checkOutput("nb1_ready", cycles1(B_READY), at(14) | at(20));
        checkOutput("nb1_p12", cycles1(B_P12), at(1) | at(19));
        checkOutput("nb1_p6", cycles1(B_P6), at(13));
        checkOutput("nb1_final_block", 64'(trace1[20] & (O_XKB | O_XDB | O_CIPH)), 64'(O_XKB | O_XDB | O_CIPH));
        checkOutput("nb1_tag", cycles1(B_TAG), at(31));
        checkOutput("nb1_end", cycles1(B_END), at(32));

        $display("[TB] stall run");
        reset_pulse();
        run_trace(1'b0, 1'b1);
        checkOutput("stall_ready", cycles4(B_READY),
                    at(14) | at(20) | at(26) | at(27) | at(28) | at(29) | at(35) | at(41));
        checkOutput("stall_frozen", 64'((trace4[26] | trace4[27] | trace4[28]) & RUN), 64'd0);
        checkOutput("stall_round_c28", 64'(rtrace4[28]), 64'd6);
        checkOutput("stall_end", cycles4(B_END), at(53));

        $display("[TB] reset during PT_RUN");
        reset_pulse();
        for (int c = 0; c < 41; c++) applyStimulus(c == 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        run_trace(1'b0, 1'b0);
        check_nominal4("post_rst");

        $display("[TB] start held through END");
        reset_pulse();
        run_trace(1'b1, 1'b0);
        checkOutput("hold_end_only", 64'(trace4[50]), 64'(O_END));
        checkOutput("hold_idle_once", 64'(trace4[51]), 64'd0);
        checkOutput("hold_restart", 64'(trace4[52]), 64'(O_CONF));
        checkOutput("hold_nb1_end_only", 64'(trace1[32]), 64'(O_END));
        checkOutput("hold_nb1_idle_once", 64'(trace1[33]), 64'd0);
        checkOutput("hold_nb1_restart", 64'(trace1[34]), 64'(O_CONF));
        for (int c = 0; c < 80; c++) applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++)
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 499) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
